// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: per-stage write/bubble enables.
// Optional performance counters: define PIPELINE_CTRL_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             br_taken_ex,
    input  logic             md_req_ex,
    input  logic             md_done,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             md_start,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MD_WAIT  = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] W_LAST = WCW'(MEM_TIMEOUT - 1);

    logic [1:0]     r_state;
    logic [WCW-1:0] r_wait;
    logic           r_err;

    logic [1:0] w_next;
    logic       w_wait_clr;
    logic       w_wait_inc;
    logic       w_set_err;
    logic       w_rel;
    logic       w_wd_fire;
    logic       w_mds;
    logic       w_pcw;
    logic       w_ifw;
    logic       w_idw;
    logic       w_exw;
    logic       w_mww;
    logic       w_iff;
    logic       w_idf;
    logic       w_exf;
    logic       w_mwf;

    assign w_wd_fire = (MEM_TIMEOUT > 0) && !dmem_ready && (r_wait == W_LAST);

    always_comb begin
        w_next     = r_state;
        w_wait_clr = 1'b0;
        w_wait_inc = 1'b0;
        w_set_err  = 1'b0;
        w_rel      = 1'b0;
        w_mds      = 1'b0;
        w_pcw      = 1'b1;
        w_ifw      = 1'b1;
        w_idw      = 1'b1;
        w_exw      = 1'b1;
        w_mww      = 1'b1;
        w_iff      = 1'b0;
        w_idf      = 1'b0;
        w_exf      = 1'b0;
        w_mwf      = 1'b0;
        case (r_state)
            MD_WAIT: begin
                if (!md_done) begin
                    w_pcw = 1'b0;
                    w_ifw = 1'b0;
                    w_idw = 1'b0;
                    w_exf = 1'b1;
                end else begin
                    w_next = RUN;
                    if (load_use_stall) begin
                        w_pcw = 1'b0;
                        w_ifw = 1'b0;
                        w_idf = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_ready || w_wd_fire) begin
                    w_rel     = 1'b1;
                    w_set_err = w_wd_fire;
                end else begin
                    w_pcw      = 1'b0;
                    w_ifw      = 1'b0;
                    w_idw      = 1'b0;
                    w_exw      = 1'b0;
                    w_mwf      = 1'b1;
                    w_wait_inc = 1'b1;
                end
            end
            default: begin
                if (dmem_req_mem && !dmem_ready) begin
                    w_pcw      = 1'b0;
                    w_ifw      = 1'b0;
                    w_idw      = 1'b0;
                    w_exw      = 1'b0;
                    w_mwf      = 1'b1;
                    w_next     = MEM_WAIT;
                    w_wait_clr = 1'b1;
                end else begin
                    w_rel = 1'b1;
                end
            end
        endcase
        // Released (or plain RUN): MUL/DIV, then branch, then load-use.
        if (w_rel) begin
            w_next = RUN;
            if (md_req_ex) begin
                w_mds  = 1'b1;
                w_pcw  = 1'b0;
                w_ifw  = 1'b0;
                w_idw  = 1'b0;
                w_exf  = 1'b1;
                w_next = MD_WAIT;
            end else if (br_taken_ex) begin
                w_iff = 1'b1;
                w_idf = 1'b1;
            end else if (load_use_stall) begin
                w_pcw = 1'b0;
                w_ifw = 1'b0;
                w_idf = 1'b1;
            end
        end
    end

    assign md_start     = rst_n & w_mds;
    assign pc_write     = rst_n & w_pcw;
    assign if_id_write  = rst_n & w_ifw;
    assign id_ex_write  = rst_n & w_idw;
    assign ex_mem_write = rst_n & w_exw;
    assign mem_wb_write = rst_n & w_mww;
    assign if_id_flush  = ~rst_n | w_iff;
    assign id_ex_flush  = ~rst_n | w_idf;
    assign ex_mem_flush = ~rst_n | w_exf;
    assign mem_wb_flush = ~rst_n | w_mwf;
    assign state        = r_state;
    assign err_timeout  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wait_clr)
                r_wait <= '0;
            else if (w_wait_inc)
                r_wait <= r_wait + 1'b1;
            if (w_set_err)
                r_err <= 1'b1;
        end
    end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;

    // if_id_flush outside reset is only ever raised by a taken branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (!w_pcw && (r_stall != '1))
                r_stall <= r_stall + 1'b1;
            if (w_iff && (r_flush != '1))
                r_flush <= r_flush + 1'b1;
        end
    end

    assign stall_cnt = r_stall;
    assign flush_cnt = r_flush;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors, decoupled monitor.
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use_stall = 1'b0;
    logic br_taken_ex = 1'b0;
    logic md_req_ex = 1'b0;
    logic md_done = 1'b0;
    logic dmem_req_mem = 1'b0;
    logic dmem_ready = 1'b0;
    logic md_start;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] state;
    logic err_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_stall(load_use_stall), .br_taken_ex(br_taken_ex),
        .md_req_ex(md_req_ex), .md_done(md_done),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .md_start(md_start), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .state(state), .err_timeout(err_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0]      v;
        logic [CNT_W-1:0] s;
        logic [CNT_W-1:0] f;
        string            nm;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] e_stall = '0;
    logic [CNT_W-1:0] e_flush = '0;

    // v = {state, md_start, pc/if_id/id_ex/ex_mem/mem_wb write, four flushes, err}
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [12:0] got;
            e = sb.pop_front();
            got = {state, md_start, pc_write, if_id_write, id_ex_write,
                   ex_mem_write, mem_wb_write, if_id_flush, id_ex_flush,
                   ex_mem_flush, mem_wb_flush, err_timeout};
            n_vec++;
            if (got !== e.v || stall_cnt !== e.s || flush_cnt !== e.f) begin
                n_bad++;
                $display("FAIL %s: got %b stall=%0d flush=%0d, want %b stall=%0d flush=%0d",
                         e.nm, got, stall_cnt, flush_cnt, e.v, e.s, e.f);
            end
        end
    end

    // in = {lu, br, md_req, md_done, dmem_req, dmem_ready}
    task automatic ap(input logic rst, input logic [5:0] in,
                      input logic [1:0] st, input logic mds,
                      input logic [4:0] w, input logic [3:0] f,
                      input logic err, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        {load_use_stall, br_taken_ex, md_req_ex, md_done,
         dmem_req_mem, dmem_ready} = in;
        if (!rst) begin
            e_stall = '0;
            e_flush = '0;
        end
        e.v = {st, mds, w, f, err};
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        e.s = e_stall;
        e.f = e_flush;
        if (rst && !w[4]) e_stall = e_stall + 1'b1;
        if (rst && f[3]) e_flush = e_flush + 1'b1;
`else
        e.s = '0;
        e.f = '0;
`endif
        e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        ap(0, 6'b000000, 0, 0, 5'b00000, 4'b1111, 0, "reset_idle");
        ap(0, 6'b111111, 0, 0, 5'b00000, 4'b1111, 0, "reset_forced");
        ap(1, 6'b000000, 0, 0, 5'b11111, 4'b0000, 0, "run_idle");
        ap(1, 6'b100000, 0, 0, 5'b00111, 4'b0100, 0, "load_use");
        ap(1, 6'b000000, 0, 0, 5'b11111, 4'b0000, 0, "lu_released");
        ap(1, 6'b110000, 0, 0, 5'b11111, 4'b1100, 0, "br_over_lu");
        ap(1, 6'b001000, 0, 1, 5'b00011, 4'b0010, 0, "md_start");
        ap(1, 6'b001000, 1, 0, 5'b00011, 4'b0010, 0, "md_wait1");
        ap(1, 6'b001010, 1, 0, 5'b00011, 4'b0010, 0, "md_wait_dmem_ign");
        ap(1, 6'b001000, 1, 0, 5'b00011, 4'b0010, 0, "md_wait3");
        ap(1, 6'b001000, 1, 0, 5'b00011, 4'b0010, 0, "md_wait4");
        ap(1, 6'b001100, 1, 0, 5'b11111, 4'b0000, 0, "md_done");
        ap(1, 6'b000100, 0, 0, 5'b11111, 4'b0000, 0, "md_done_ignored");
        ap(1, 6'b010010, 0, 0, 5'b00001, 4'b0001, 0, "mem_freeze_run");
        ap(1, 6'b010010, 2, 0, 5'b00001, 4'b0001, 0, "mem_wait1");
        ap(1, 6'b010010, 2, 0, 5'b00001, 4'b0001, 0, "mem_wait2");
        ap(1, 6'b010011, 2, 0, 5'b11111, 4'b1100, 0, "mem_ready_br");
        ap(1, 6'b000000, 0, 0, 5'b11111, 4'b0000, 0, "after_mem");
        ap(1, 6'b000010, 0, 0, 5'b00001, 4'b0001, 0, "wd_enter");
        ap(1, 6'b000010, 2, 0, 5'b00001, 4'b0001, 0, "wd_wait0");
        ap(1, 6'b000010, 2, 0, 5'b00001, 4'b0001, 0, "wd_wait1");
        ap(1, 6'b000010, 2, 0, 5'b00001, 4'b0001, 0, "wd_wait2");
        ap(1, 6'b000010, 2, 0, 5'b11111, 4'b0000, 0, "wd_release");
        ap(1, 6'b000000, 0, 0, 5'b11111, 4'b0000, 1, "err_set");
        ap(1, 6'b000000, 0, 0, 5'b11111, 4'b0000, 1, "err_sticky");
        ap(1, 6'b001000, 0, 1, 5'b00011, 4'b0010, 1, "md_start2");
        ap(1, 6'b001000, 1, 0, 5'b00011, 4'b0010, 1, "md_wait_pre_rst");
        ap(0, 6'b001000, 0, 0, 5'b00000, 4'b1111, 0, "async_reset");
        ap(1, 6'b000000, 0, 0, 5'b11111, 4'b0000, 0, "post_reset");
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RISC-V pipeline. It combines the load-use stall request, taken-branch redirects from EX, a multi-cycle MUL/DIV unit handshake and data-memory wait states into a single set of per-stage write and flush enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sits beside the hazard unit and drives every pipeline register's enable and bubble inputs.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before a forced release; 0 disables the watchdog.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_use_stall  in  1  load-use stall request from the hazard unit
br_taken_ex  in  1  branch/jump in EX resolved taken
md_req_ex  in  1  EX holds a MUL/DIV instruction
md_done  in  1  MUL/DIV unit result valid (1-cycle pulse)
dmem_req_mem  in  1  MEM stage performs a data access
dmem_ready  in  1  data memory completes the access this cycle
md_start  out  1  1-cycle start pulse to the MUL/DIV unit
pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register load enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble (NOP) instead of data
state  out  2  RUN=0, MD_WAIT=1, MEM_WAIT=2
err_timeout  out  1  sticky watchdog flag
stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- During reset, outputs are forced regardless of inputs:
  - state=RUN; all *_write=0; all *_flush=1; md_start=0.
  - err_timeout=0; counters=0; internal wait_cnt=0.
- All enables are combinational from state and inputs; state and counters update on the rising edge of clk.
- Default (no event): all *_write=1, all *_flush=0, md_start=0.
- RUN priority, highest first:
  1. dmem_req_mem && !dmem_ready:
     - pc/if_id/id_ex/ex_mem write=0; mem_wb_flush=1.
     - Next state MEM_WAIT, wait_cnt<=0.
     - br_taken_ex, md_req_ex and load_use_stall are ignored; they are held frozen and re-evaluated on release.
  2. md_req_ex:
     - md_start=1; pc/if_id/id_ex write=0; ex_mem_flush=1.
     - Next state MD_WAIT.
  3. br_taken_ex:
     - pc_write=1 (target loaded); if_id_flush=1; id_ex_flush=1.
     - load_use_stall is ignored.
  4. load_use_stall:
     - pc_write=0; if_id_write=0; id_ex_flush=1.
- MD_WAIT:
  - While !md_done: pc/if_id/id_ex write=0; ex_mem_flush=1; md_start=0.
  - dmem inputs are ignored, because MEM holds a bubble.
  - On md_done: default enables (EX instruction advances), with load_use_stall applied per RUN rule 4; next state RUN.
- MEM_WAIT:
  - While !dmem_ready: enables as in RUN rule 1.
  - On dmem_ready: mem_wb_write=1 with no flush; RUN rules 2-4 are evaluated this cycle (rule 1 is skipped); next state as those rules dictate, else RUN.
  - Watchdog (MEM_TIMEOUT>0): on a cycle with !dmem_ready and wait_cnt==MEM_TIMEOUT-1, behave exactly as dmem_ready=1 and set err_timeout<=1. Otherwise wait_cnt increments.
  - Maximum residency in MEM_WAIT is MEM_TIMEOUT cycles.
- md_done outside MD_WAIT is ignored.
- err_timeout clears only on reset.
- Illegal state value 3: treated as RUN; next state RUN.

Optional Feature:
PIPELINE_CTRL_PERF_CNT_EN
- Defined:
  - stall_cnt increments on every cycle with pc_write=0 outside reset.
  - flush_cnt increments on every cycle with if_id_flush=1 caused by br_taken_ex.
  - Both saturate at all-ones and clear only on reset.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Load-use: load_use_stall=1 for 1 cycle in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly that cycle; state stays 0.
- Branch plus load-use: br_taken_ex=1 and load_use_stall=1 together -> pc_write=1, if_id_flush=1, id_ex_flush=1; stall_cnt unchanged.
- MUL/DIV: md_req_ex=1, md_done 5 cycles later -> md_start high 1 cycle; state=1 for 5 cycles; pc_write=0 and ex_mem_flush=1 throughout; cycle after md_done state=0.
- Memory wait with branch: dmem_req_mem=1, dmem_ready=0 for 3 cycles, br_taken_ex=1 held -> freeze for 3 cycles with mem_wb_flush=1; on the ready cycle mem_wb_write=1 and branch flush applied; state=0.
- Watchdog: MEM_TIMEOUT=4, dmem_ready never asserted -> exactly 4 MEM_WAIT cycles; forced release; err_timeout=1 remains set until rst_n=0.
- Async reset: rst_n low mid-MD_WAIT -> state=0, all writes 0, flushes 1 immediately without a clock edge; counters=0; md_start=0.
